// File: rtl/fp_unpack_pipe.sv
// Two-stage IEEE-754 single/double operand unpacker with valid/ready flow control.
// Stage 1 extracts fields and classifies; stage 2 normalises denormals and forms the exponent.
module fp_unpack_pipe #(
  parameter int N  = 64,
  parameter int EW = 13,
  parameter int SW = 53
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          dbs,
  input  logic [N-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          s,
  output logic [EW-1:0] e,
  output logic [SW-1:0] f,
  output logic [5:0]    lz,
  output logic          fz,
  output logic          zero,
  output logic          denorm,
  output logic          inf,
  output logic          nan,
  output logic          snan
);

  logic v1, v2;
  logic s1_ld, s2_ld;

  assign s2_ld     = !v2 || out_ready;
  assign s1_ld     = !v1 || s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = v2;

  // stage 1 combinational field extraction
  logic [10:0]   ex_c;
  logic [51:0]   frac_c;
  logic          msb_c;
  logic          emax_c;
  logic          fz_c;
  logic [SW-1:0] r_c;
  logic [5:0]    lz_c;

  always_comb begin
    if (dbs) begin
      ex_c   = x[62:52];
      frac_c = x[51:0];
      msb_c  = x[51];
      emax_c = (x[62:52] == 11'h7FF);
    end else begin
      ex_c   = {3'b000, x[62:55]};
      frac_c = {x[54:32], 29'b0};
      msb_c  = x[54];
      emax_c = (x[62:55] == 8'hFF);
    end
    fz_c = (frac_c == '0);
    r_c  = {(ex_c != '0), frac_c};
    // ascending scan: the last hit is the highest set bit
    lz_c = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (r_c[i]) lz_c = 6'(SW - 1 - i);
    end
  end

  logic          s1_s, s1_dbs, s1_fz;
  logic [10:0]   s1_ex;
  logic [SW-1:0] s1_r;
  logic [5:0]    s1_lz;
  logic          s1_zero, s1_den, s1_inf, s1_nan, s1_snan;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_s    <= 1'b0;
      s1_dbs  <= 1'b0;
      s1_fz   <= 1'b0;
      s1_ex   <= '0;
      s1_r    <= '0;
      s1_lz   <= '0;
      s1_zero <= 1'b0;
      s1_den  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_nan  <= 1'b0;
      s1_snan <= 1'b0;
    end else if (s1_ld) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_s    <= x[63];
        s1_dbs  <= dbs;
        s1_fz   <= fz_c;
        s1_ex   <= ex_c;
        s1_r    <= r_c;
        s1_lz   <= lz_c;
        s1_zero <= (ex_c == '0) && fz_c;
        s1_den  <= (ex_c == '0) && !fz_c;
        s1_inf  <= emax_c && fz_c;
        s1_nan  <= emax_c && !fz_c;
        s1_snan <= emax_c && !fz_c && !msb_c;
      end
    end
  end

  // stage 2 combinational normalisation
  logic [EW-1:0] bias_c;
  logic [EW-1:0] e_c;
  logic [SW-1:0] f_c;

  always_comb begin
    bias_c = s1_dbs ? EW'(1023) : EW'(127);
    e_c    = EW'(s1_ex) - bias_c;
    f_c    = s1_r;
    if (s1_zero) begin
      e_c = '0;
      f_c = '0;
    end else if (s1_den) begin
      e_c = EW'(1) - bias_c - EW'(s1_lz);
      f_c = s1_r << s1_lz;
    end else if (s1_inf || s1_nan) begin
      e_c = s1_dbs ? EW'(1024) : EW'(128);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      s      <= 1'b0;
      e      <= '0;
      f      <= '0;
      lz     <= '0;
      fz     <= 1'b0;
      zero   <= 1'b0;
      denorm <= 1'b0;
      inf    <= 1'b0;
      nan    <= 1'b0;
      snan   <= 1'b0;
    end else if (s2_ld) begin
      v2 <= v1;
      if (v1) begin
        s      <= s1_s;
        e      <= e_c;
        f      <= f_c;
        lz     <= s1_lz;
        fz     <= s1_fz;
        zero   <= s1_zero;
        denorm <= s1_den;
        inf    <= s1_inf;
        nan    <= s1_nan;
        snan   <= s1_snan;
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Scoreboard bench for fp_unpack_pipe: directed IEEE corner cases, stall, reset flush,
// and randomized operands under random backpressure against an arithmetic reference model.
module tb_fp_unpack_pipe;

  typedef struct packed {
    logic        s;
    logic [12:0] e;
    logic [52:0] f;
    logic [5:0]  lz;
    logic        fz, zero, denorm, inf, nan, snan;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        dbs = 1'b0;
  logic [63:0] x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        s;
  logic [12:0] e;
  logic [52:0] f;
  logic [5:0]  lz;
  logic        fz, zero, denorm, inf, nan, snan;

  fp_unpack_pipe #(.N(64), .EW(13), .SW(53)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .dbs(dbs), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .e(e), .f(f), .lz(lz), .fz(fz),
    .zero(zero), .denorm(denorm), .inf(inf), .nan(nan), .snan(snan)
  );

  always #5 clk = ~clk;

  int   vecs = 0;
  int   miscompares = 0;
  int   accepted = 0;
  res_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decode the IEEE fields and derive value exponent / significand arithmetically.
  function automatic res_t model(input logic d, input logic [63:0] v);
    res_t        m;
    int          exf, bias, emax, ev, lzc;
    logic [51:0] frac;
    logic [52:0] r;
    logic        qbit;
    if (d) begin
      exf = int'(v[62:52]); frac = v[51:0]; bias = 1023; emax = 2047; qbit = v[51];
    end else begin
      exf = int'(v[62:55]); frac = {v[54:32], 29'd0}; bias = 127; emax = 255; qbit = v[54];
    end
    r = {exf != 0, frac};
    lzc = 0;
    if (r != 0) begin
      lzc = 53;
      while (r != 0) begin r = r >> 1; lzc--; end
      r = {exf != 0, frac};
    end
    m.s      = v[63];
    m.fz     = (frac == 0);
    m.lz     = lzc[5:0];
    m.zero   = (exf == 0) && (frac == 0);
    m.denorm = (exf == 0) && (frac != 0);
    m.inf    = (exf == emax) && (frac == 0);
    m.nan    = (exf == emax) && (frac != 0);
    m.snan   = m.nan && !qbit;
    if (m.zero) begin
      ev = 0; m.f = '0;
    end else if (m.denorm) begin
      ev = (1 - bias) - lzc;       // value = frac * 2^(1-bias-52); renormalise to a leading 1
      m.f = r * (53'd1 << lzc);
    end else begin
      ev = exf - bias; m.f = r;    // inf/nan: exf==emax gives emax-bias
    end
    m.e = ev[12:0];
    return m;
  endfunction

  function automatic logic [63:0] rand_op(input logic d);
    logic [63:0] v;
    int          k;
    v = {$urandom, $urandom};
    k = $urandom_range(0, 6);
    if (d) begin
      if (k == 0 || k == 2 || k == 5) v[62:52] = '0;
      if (k == 1 || k == 3) v[62:52] = 11'h7FF;
      if (k == 2 || k == 3) v[51:0] = '0;
      if (k == 5) v[51:0] = 52'd1 << $urandom_range(0, 51);
    end else begin
      if (k == 0 || k == 2 || k == 5) v[62:55] = '0;
      if (k == 1 || k == 3) v[62:55] = 8'hFF;
      if (k == 2 || k == 3) v[54:32] = '0;
      if (k == 5) v[54:32] = 23'd1 << $urandom_range(0, 22);
    end
    return v;
  endfunction

  task automatic send(input logic d, input logic [63:0] v);
    int unsigned n;
    n = 0;
    in_valid = 1'b1; dbs = d; x = v;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) begin
      chk("in_ready_timeout", 128'(in_ready), 128'd1);
    end else begin
      sb.push_back(model(d, v));
      accepted++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; dbs = $urandom_range(0, 1) != 0; x = {$urandom, $urandom};
  endtask

  res_t act, prev_act, exp_r;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    act = {s, e, f, lz, fz, zero, denorm, inf, nan, snan};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 128'(act), 128'(prev_act));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 128'(out_valid), 128'd0);
        end else begin
          exp_r = sb.pop_front();
          chk("result", 128'(act), 128'(exp_r));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_act   = act;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic done = 1'b0;
  int   base, n;

  initial begin
    #2;
    chk("rst_outputs", 128'({s, e, f, lz, fz, zero, denorm, inf, nan, snan}), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    // directed corner cases
    send(1'b1, 64'h3FF0000000000000);
    send(1'b1, 64'h0000000000000001);
    send(1'b0, 64'h0000000100000000);
    send(1'b1, 64'h7FF0000000000001);
    send(1'b1, 64'h7FF8000000000000);
    send(1'b1, 64'hFFF0000000000000);
    send(1'b1, 64'h0000000000000000);
    send(1'b0, 64'h80000000DEADBEEF);
    send(1'b0, 64'h7F800000_00000000);
    send(1'b0, 64'h7FA00000_12345678);
    repeat (4) @(posedge clk); #1;

    // stall: consumer blocked while 8 operands stream in
    out_ready = 1'b0;
    base = accepted;
    fork
      for (int i = 0; i < 8; i++) begin
        logic d;
        d = $urandom_range(0, 1) != 0;
        send(d, rand_op(d));
      end
      begin
        repeat (6) @(negedge clk);
        chk("stall_in_ready", 128'(in_ready), 128'd0);
        chk("stall_accepted", 128'(accepted - base), 128'd2);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // reset with two operands in flight
    send(1'b1, 64'h4000000000000000);
    send(1'b0, 64'h40490FDB00000000);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 128'(out_valid), 128'd0);
    end
    @(posedge clk); #1;
    send(1'b1, 64'hC00921FB54442D18);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk("post_rst_latency", 128'(n), 128'd2);
    @(posedge clk); #1;

    // random operands with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic d;
          d = $urandom_range(0, 1) != 0;
          send(d, rand_op(d));
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("drain_empty", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
